video_arbiter: RTL and testbench



---
 rtl/video_arbiter.sv | 178 +++++++++++++++++
 tb/tb_video_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_arbiter.sv
// Shares the single SRAM port between CRTC display fetches and the CPU/Pi requesters, using four fixed 4-cycle windows per 16-cycle character slot.
// Requester ack arrives 4 cycles after its window opens; an early cclk_en aborts the open window. `define VIDEO_REVERSE_EN enables PET reverse video.
module video_arbiter #(
  parameter int                ADDR_W       = 17,
  parameter int                MA_W         = 11,
  parameter logic [ADDR_W-1:0] VRAM_BASE    = 17'h08000,
  parameter logic [ADDR_W-1:0] CHARROM_BASE = 17'h10000
) (
  input  logic              clk16,
  input  logic              res_b,
  input  logic              cclk_en,
  input  logic              de,
  input  logic [MA_W-1:0]   ma,
  input  logic [2:0]        ra,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  input  logic              pi_req,
  input  logic              pi_we,
  input  logic [ADDR_W-1:0] pi_addr,
  input  logic [7:0]        pi_wdata,
  output logic              pi_ack,
  output logic [7:0]        pi_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        pixel_data,
  output logic              pixel_valid
);

  typedef enum logic [2:0] {IDLE, VID_CHAR, VID_ROM, REQ_CPU, REQ_PI} state_t;

  state_t              state, owner;
  logic [3:0]          phase, nxt_phase;
  logic                slot_active, nxt_active;
  logic                de_l, nxt_de;
  logic [MA_W-1:0]     ma_l, nxt_ma;
  logic [2:0]          ra_l, nxt_ra;
  logic [7:0]          char_code, char_nxt, rom_index, pix_nxt;
  logic                last_pi, acc_we, oe_q, we_q;
  logic                early, win_end, win_start, cpu_pend, pi_pend;
  logic [ADDR_W-1:0]   owner_addr;
  logic [7:0]          owner_wdata;
  logic                owner_we;

  // An early slot pulse must kill the strobes in the cycle it arrives, ahead of the register update.
  assign ram_oe = oe_q & ~early;
  assign ram_we = we_q & ~early;

  always_comb begin
    early      = cclk_en && slot_active && (phase != 4'd15);
    win_end    = slot_active && (phase[1:0] == 2'd3) && !early;
    nxt_active = cclk_en || (slot_active && (phase != 4'd15));
    if (cclk_en)
      nxt_phase = 4'd0;
    else if (slot_active && (phase != 4'd15))
      nxt_phase = phase + 4'd1;
    else
      nxt_phase = phase;
    win_start = nxt_active && (nxt_phase[1:0] == 2'd0);
    nxt_de    = cclk_en ? de : de_l;
    nxt_ma    = cclk_en ? ma : ma_l;
    nxt_ra    = cclk_en ? ra : ra_l;

    // A requester finishing on this edge is not pending again until its ack cycle.
    cpu_pend = cpu_req && !(win_end && (state == REQ_CPU));
    pi_pend  = pi_req  && !(win_end && (state == REQ_PI));

    // Window 1 opens on the same edge that captures the character code.
    char_nxt = (win_end && (state == VID_CHAR)) ? ram_rdata : char_code;
`ifdef VIDEO_REVERSE_EN
    rom_index = {1'b0, char_nxt[6:0]};
    pix_nxt   = ram_rdata ^ {8{char_code[7]}};
`else
    rom_index = char_nxt;
    pix_nxt   = ram_rdata;
`endif

    owner       = IDLE;
    owner_addr  = ram_addr;
    owner_wdata = ram_wdata;
    owner_we    = 1'b0;
    if (nxt_de && (nxt_phase[3:2] == 2'd0)) begin
      owner      = VID_CHAR;
      owner_addr = VRAM_BASE + {{(ADDR_W-MA_W){1'b0}}, nxt_ma};
    end else if (nxt_de && (nxt_phase[3:2] == 2'd1)) begin
      owner      = VID_ROM;
      owner_addr = CHARROM_BASE | {{(ADDR_W-11){1'b0}}, rom_index, nxt_ra};
    end else if (cpu_pend && (!pi_pend || last_pi)) begin
      owner       = REQ_CPU;
      owner_addr  = cpu_addr;
      owner_wdata = cpu_wdata;
      owner_we    = cpu_we;
    end else if (pi_pend) begin
      owner       = REQ_PI;
      owner_addr  = pi_addr;
      owner_wdata = pi_wdata;
      owner_we    = pi_we;
    end
  end

  always_ff @(posedge clk16 or negedge res_b) begin
    if (!res_b) begin
      phase       <= 4'd15;
      slot_active <= 1'b0;
      de_l        <= 1'b0;
      ma_l        <= '0;
      ra_l        <= '0;
      state       <= IDLE;
      last_pi     <= 1'b1;
      char_code   <= 8'h00;
      acc_we      <= 1'b0;
      oe_q        <= 1'b0;
      we_q        <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= 8'h00;
      cpu_ack     <= 1'b0;
      pi_ack      <= 1'b0;
      cpu_rdata   <= 8'h00;
      pi_rdata    <= 8'h00;
      pixel_data  <= 8'h00;
      pixel_valid <= 1'b0;
    end else begin
      phase       <= nxt_phase;
      slot_active <= nxt_active;
      de_l        <= nxt_de;
      ma_l        <= nxt_ma;
      ra_l        <= nxt_ra;
      cpu_ack     <= 1'b0;
      pi_ack      <= 1'b0;
      pixel_valid <= 1'b0;

      if (win_end) begin
        case (state)
          VID_CHAR: char_code <= ram_rdata;
          VID_ROM: begin
            pixel_data  <= pix_nxt;
            pixel_valid <= 1'b1;
          end
          REQ_CPU: begin
            cpu_ack <= 1'b1;
            last_pi <= 1'b0;
            if (!acc_we) cpu_rdata <= ram_rdata;
          end
          REQ_PI: begin
            pi_ack  <= 1'b1;
            last_pi <= 1'b1;
            if (!acc_we) pi_rdata <= ram_rdata;
          end
          default: ;
        endcase
      end

      if (win_start) begin
        state     <= owner;
        ram_addr  <= owner_addr;
        ram_wdata <= owner_wdata;
        acc_we    <= owner_we;
        oe_q      <= (owner != IDLE) && !owner_we;
        we_q      <= 1'b0;
      end else if (!nxt_active) begin
        state  <= IDLE;
        acc_we <= 1'b0;
        oe_q   <= 1'b0;
        we_q   <= 1'b0;
      end else begin
        // Write strobe inset to window cycles 1-2 so address and data settle around it.
        we_q <= acc_we && ((nxt_phase[1:0] == 2'd1) || (nxt_phase[1:0] == 2'd2));
      end
    end
  end

endmodule

// File: tb/tb_video_arbiter.sv
// Scoreboard bench for video_arbiter: acks and pixel strobes are checked against queued expectations.
module tb_video_arbiter;
  localparam int ADDR_W = 17;
  localparam int MA_W   = 11;

  logic              clk16 = 1'b0, res_b = 1'b0, cclk_en = 1'b0, de = 1'b0;
  logic [MA_W-1:0]   ma = '0;
  logic [2:0]        ra = 3'd0;
  logic              cpu_req = 1'b0, cpu_we = 1'b0, pi_req = 1'b0, pi_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0, pi_addr = '0;
  logic [7:0]        cpu_wdata = 8'h00, pi_wdata = 8'h00;
  logic              cpu_ack, pi_ack, ram_we, ram_oe, pixel_valid;
  logic [7:0]        cpu_rdata, pi_rdata, ram_wdata, ram_rdata, pixel_data;
  logic [ADDR_W-1:0] ram_addr;

  logic [7:0] mem [0:131071];

  typedef struct packed {
    logic [7:0] dat;
    logic [3:0] ph;
    logic       chk_dat;
  } exp_t;

  exp_t cpu_q[$], pi_q[$], pix_q[$];
  exp_t mon_e;
  int   vectors = 0, miscompares = 0;
  int   we_cnt = 0, oe_cnt = 0;
  logic [3:0] tb_phase;
  logic tb_active;
  logic auto_slot = 1'b0, early6 = 1'b0, gen_fire, gen_abort;

  video_arbiter dut (
    .clk16(clk16), .res_b(res_b), .cclk_en(cclk_en), .de(de), .ma(ma), .ra(ra),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .pi_req(pi_req), .pi_we(pi_we), .pi_addr(pi_addr), .pi_wdata(pi_wdata),
    .pi_ack(pi_ack), .pi_rdata(pi_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_oe(ram_oe), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .pixel_data(pixel_data), .pixel_valid(pixel_valid)
  );

  always #31 clk16 = ~clk16;

  assign ram_rdata = ram_oe ? mem[ram_addr] : 8'hEE;
  always @(posedge clk16) if (ram_we) mem[ram_addr] = ram_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic [3:0] p, input logic c);
    exp_t e;
    e.dat = d; e.ph = p; e.chk_dat = c;
    return e;
  endfunction

  function automatic logic [7:0] exp_pixel(input logic [MA_W-1:0] m, input logic [2:0] r);
    logic [7:0] c, idx, rom;
    c = mem[17'h08000 + {6'b0, m}];
`ifdef VIDEO_REVERSE_EN
    idx = {1'b0, c[6:0]};
`else
    idx = c;
`endif
    rom = mem[17'h10000 | {6'b0, idx, r}];
`ifdef VIDEO_REVERSE_EN
    return rom ^ {8{c[7]}};
`else
    return rom;
`endif
  endfunction

  // Reference slot timer: phase 0 follows the cclk_en edge, stops after 15.
  always @(posedge clk16 or negedge res_b) begin
    if (!res_b) begin
      tb_phase <= 4'd15; tb_active <= 1'b0;
    end else if (cclk_en) begin
      tb_phase <= 4'd0; tb_active <= 1'b1;
    end else if (tb_active) begin
      if (tb_phase == 4'd15) tb_active <= 1'b0;
      else tb_phase <= tb_phase + 4'd1;
    end
  end

  // Slot pulse generator; pushes the expected pixel for every display slot it opens.
  always @(negedge clk16) begin
    gen_fire  = auto_slot && (tb_phase == 4'd15);
    gen_abort = early6 && tb_active && (tb_phase == 4'd6);
    if (gen_abort) begin
      chk("abort_pre_oe", ram_oe, 1'b1);
      early6 = 1'b0;
    end
    if (res_b && (gen_fire || gen_abort)) begin
      cclk_en = 1'b1;
      if (de) pix_q.push_back(mk(exp_pixel(ma, ra), 4'd8, 1'b1));
    end else begin
      cclk_en = 1'b0;
    end
    if (gen_abort) begin
      #1;
      chk("abort_oe_drop", ram_oe, 1'b0);
      chk("abort_we_drop", ram_we, 1'b0);
    end
  end

  always @(posedge clk16) begin
    #1;
    if (res_b) begin
      if (ram_oe) oe_cnt++;
      if (ram_we) begin
        we_cnt++;
        chk("we_inset", (tb_phase[1:0] == 2'd1) || (tb_phase[1:0] == 2'd2), 1'b1);
      end
      if (cpu_ack) begin
        if (cpu_q.size() == 0) chk("cpu_ack_unexpected", cpu_ack, 1'b0);
        else begin
          mon_e = cpu_q.pop_front();
          chk("cpu_ack_phase", tb_phase, mon_e.ph);
          if (mon_e.chk_dat) chk("cpu_rdata", cpu_rdata, mon_e.dat);
        end
      end
      if (pi_ack) begin
        if (pi_q.size() == 0) chk("pi_ack_unexpected", pi_ack, 1'b0);
        else begin
          mon_e = pi_q.pop_front();
          chk("pi_ack_phase", tb_phase, mon_e.ph);
          if (mon_e.chk_dat) chk("pi_rdata", pi_rdata, mon_e.dat);
        end
      end
      if (pixel_valid) begin
        if (pix_q.size() == 0) chk("pixel_valid_unexpected", pixel_valid, 1'b0);
        else begin
          mon_e = pix_q.pop_front();
          chk("pixel_phase", tb_phase, mon_e.ph);
          chk("pixel_data", pixel_data, mon_e.dat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk16);
    #1;
  endtask

  task automatic wait_phase(input logic [3:0] p);
    int n;
    n = 0;
    while (!(tb_active && (tb_phase == p)) && (n < 64)) begin
      tick();
      n++;
    end
    if (n >= 64) chk("wait_phase_timeout", tb_phase, p);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nc, np;
    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    mem[17'h00200] = 8'hA5;
    mem[17'h00300] = 8'h3C;
    mem[17'h00400] = 8'hC3;
    mem[17'h08000] = 8'h41;
    mem[17'h1020A] = 8'h7E;
    mem[17'h08005] = 8'hC1;
    mem[17'h1020B] = 8'h18;
    mem[17'h1060B] = 8'h99;

    // Reset state
    repeat (3) tick();
    chk("rst_ram_oe", ram_oe, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_addr", ram_addr, 17'h0);
    chk("rst_ram_wdata", ram_wdata, 8'h0);
    chk("rst_acks", {cpu_ack, pi_ack, pixel_valid}, 3'b000);
    chk("rst_rdata", {cpu_rdata, pi_rdata, pixel_data}, 24'h0);
    @(negedge clk16) res_b = 1'b1;

    // Round robin with both requesters held, display off: C,P,C,P per slot
    cpu_addr = 17'h00200; pi_addr = 17'h00300;
    for (int k = 0; k < 4; k++) begin
      cpu_q.push_back(mk(8'hA5, (k % 2 == 1) ? 4'd12 : 4'd4, 1'b1));
      pi_q.push_back(mk(8'h3C, (k % 2 == 1) ? 4'd0 : 4'd8, 1'b1));
    end
    cpu_req = 1'b1; pi_req = 1'b1; auto_slot = 1'b1;
    nc = 0; np = 0;
    for (int n = 0; n < 120; n++) begin
      tick();
      if (cpu_ack) begin nc++; if (nc == 4) cpu_req = 1'b0; end
      if (pi_ack) begin np++; if (np == 4) pi_req = 1'b0; end
      if (nc >= 4 && np >= 4) break;
    end
    chk("rr_cpu_acks", nc, 4);
    chk("rr_pi_acks", np, 4);

    // Display fetch: char 0x41, raster 2
    de = 1'b1; ma = 11'd0; ra = 3'd2;
    wait_phase(4'd15);
    wait_phase(4'd1);
    chk("vid_char_addr", ram_addr, 17'h08000);
    chk("vid_char_oe", ram_oe, 1'b1);
    wait_phase(4'd5);
    chk("vid_rom_addr", ram_addr, 17'h1020A);

    // Display fetch: char 0xC1, raster 3
    ma = 11'd5; ra = 3'd3;
    wait_phase(4'd15);
    wait_phase(4'd5);
`ifdef VIDEO_REVERSE_EN
    chk("vid_rom_addr_rev", ram_addr, 17'h1020B);
`else
    chk("vid_rom_addr_rev", ram_addr, 17'h1060B);
`endif

    // CPU write during display slot: window 2, strobe phases 9-10, ack at 12
    ma = 11'd0; ra = 3'd2;
    wait_phase(4'd15);
    wait_phase(4'd1);
    cpu_we = 1'b1; cpu_addr = 17'h00100; cpu_wdata = 8'h55; cpu_req = 1'b1;
    cpu_q.push_back(mk(8'h00, 4'd12, 1'b0));
    we_cnt = 0;
    for (int n = 0; n < 40; n++) begin tick(); if (cpu_ack) break; end
    chk("wr_ack_seen", cpu_ack, 1'b1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    chk("wr_we_cycles", we_cnt, 2);
    chk("wr_mem", mem[17'h00100], 8'h55);

    // Pi read aborted by cclk_en at phase 6, completes in the next slot
    de = 1'b0;
    wait_phase(4'd15);
    wait_phase(4'd1);
    pi_we = 1'b0; pi_addr = 17'h00400; pi_req = 1'b1;
    pi_q.push_back(mk(8'hC3, 4'd4, 1'b1));
    early6 = 1'b1;
    for (int n = 0; n < 40; n++) begin tick(); if (pi_ack) break; end
    chk("abort_ack_seen", pi_ack, 1'b1);
    pi_req = 1'b0;
    tick();
    chk("pi_rdata_hold", pi_rdata, 8'hC3);

    // Reset mid-window while a CPU read holds ram_oe
    wait_phase(4'd15);
    wait_phase(4'd1);
    cpu_we = 1'b0; cpu_addr = 17'h00200; cpu_req = 1'b1;
    auto_slot = 1'b0;
    wait_phase(4'd5);
    #10;
    chk("rst_mid_pre_oe", ram_oe, 1'b1);
    res_b = 1'b0;
    #1;
    chk("rst_mid_oe", ram_oe, 1'b0);
    chk("rst_mid_we", ram_we, 1'b0);
    chk("rst_mid_acks", {cpu_ack, pi_ack}, 2'b00);
    chk("rst_mid_pixel", pixel_data, 8'h00);
    chk("rst_mid_rdata", {cpu_rdata, pi_rdata}, 16'h0);
    @(negedge clk16) res_b = 1'b1;
    oe_cnt = 0;
    repeat (30) tick();
    chk("idle_no_window", oe_cnt, 0);
    cpu_q.push_back(mk(8'hA5, 4'd4, 1'b1));
    auto_slot = 1'b1;
    for (int n = 0; n < 40; n++) begin tick(); if (cpu_ack) break; end
    chk("post_rst_ack_seen", cpu_ack, 1'b1);
    cpu_req = 1'b0; auto_slot = 1'b0;

    repeat (40) tick();
    chk("cpu_q_empty", cpu_q.size(), 0);
    chk("pi_q_empty", pi_q.size(), 0);
    chk("pix_q_empty", pix_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
